// File: rtl/conv_pkg.sv
// Shared convolutional-code definitions: default K/N/generators,
// encoder state type and a tap parity helper (also for the decoder).
package conv_pkg;

  localparam int CONV_K = 3;
  localparam int CONV_N = 2;
  localparam logic [CONV_N*CONV_K-1:0] CONV_GEN = {3'b111, 3'b101};

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } conv_state_e;

  // Parity of one generator over {u, state}, MSB = current input.
  function automatic logic conv_parity(
    input logic [CONV_K-1:0] g,
    input logic [CONV_K-1:0] taps
  );
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_gen_parity.sv
// Combinational tap/XOR network: one parity bit per generator.
// taps_i = {u, sreg} (MSB current input); code_o[N-1] from g0.
import conv_pkg::*;

module conv_gen_parity #(
  parameter int K = CONV_K,
  parameter int N = CONV_N,
  parameter logic [N*K-1:0] GEN = CONV_GEN
) (
  input  logic [K-1:0] taps_i,
  output logic [N-1:0] code_o
);

  for (genvar j = 0; j < N; j++) begin : g_bit
    assign code_o[N-1-j] = ^(GEN[N*K-1-j*K -: K] & taps_i);
  end

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/N feed-forward convolutional encoder, zero-tail.
// Ports: clk/reset, in valid/ready/bit/last, out valid/ready/code/last, busy.
import conv_pkg::*;

module conv_encoder_framed #(
  parameter int K = CONV_K,
  parameter int N = CONV_N,
  parameter logic [N*K-1:0] GEN = CONV_GEN
) (
  input  logic         clk_sig,
  input  logic         reset_sig,
  input  logic         in_valid_sig,
  output logic         in_ready_sig,
  input  logic         in_bit_sig,
  input  logic         in_last_sig,
  output logic         out_valid_sig,
  input  logic         out_ready_sig,
  output logic [N-1:0] out_code_sig,
  output logic         out_last_sig,
  output logic         busy_sig
);

  localparam int CW = $clog2(K);

  conv_state_e  state_q, state_d;
  logic [K-2:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] code_q, code_d;
  logic         vld_q, vld_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;

  logic         slot_free;
  logic         accept;
  logic         load;
  logic         u;
  logic [K-1:0] taps;
  logic [N-1:0] sym;

  assign slot_free    = !vld_q || out_ready_sig;
  assign in_ready_sig = (state_q == RUN) && slot_free;
  assign accept       = in_valid_sig && in_ready_sig;
  assign load         = accept || ((state_q == FLUSH) && slot_free);
  assign u            = (state_q == RUN) && in_bit_sig;
  assign taps         = {u, sreg_q};

  conv_gen_parity #(
    .K   (K),
    .N   (N),
    .GEN (GEN)
  ) u_par (
    .taps_i (taps),
    .code_o (sym)
  );

  // Output register and shift state move together on every load.
  always_comb begin
    code_d = code_q;
    vld_d  = vld_q;
    last_d = last_q;
    sreg_d = sreg_q;
    if (load) begin
      code_d = sym;
      vld_d  = 1'b1;
      last_d = (state_q == FLUSH) && (cnt_q == CW'(1));
      sreg_d = taps[K-1:1];
    end else if (out_ready_sig) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (accept && in_last_sig) begin
          state_d = FLUSH;
          cnt_d   = CW'(K-1);
        end
      end
      FLUSH: begin
        if (slot_free) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A new frame accepted while the old tail leaves keeps busy high.
  always_comb begin
    busy_d = busy_q;
    if (accept)
      busy_d = 1'b1;
    else if (vld_q && out_ready_sig && last_q)
      busy_d = 1'b0;
  end

  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q <= RUN;
      sreg_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid_sig = vld_q;
  assign out_code_sig  = code_q;
  assign out_last_sig  = last_q;
  assign busy_sig      = busy_q;

endmodule
